// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the two-port data-memory arbiter.
// Holds the data width, default memory latency, FSM encoding and grant helper.
package mem_arbiter_pkg;

    localparam int unsigned REGWIDTH        = 32;
    localparam int unsigned MEM_LAT_DEFAULT = 1;
    localparam int unsigned CNT_W           = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_e;

    typedef enum logic {
        OWN_CPU = 1'b0,
        OWN_LD  = 1'b1
    } owner_e;

    typedef struct packed {
        owner_e                owner;
        logic                  we;
        logic [REGWIDTH-1:0]   addr;
        logic [REGWIDTH-1:0]   wdata;
    } txn_t;

    // On a tie the port that did not win last time gets the grant.
    function automatic owner_e pick_winner(input logic cpu_req, input logic ld_req,
                                           input owner_e last);
        if (cpu_req && ld_req) begin
            return (last == OWN_CPU) ? OWN_LD : OWN_CPU;
        end
        return ld_req ? OWN_LD : OWN_CPU;
    endfunction

endpackage

// File: rtl/mem_arbiter.sv
// Arbitrates CPU and loader ports onto one single-port data memory.
// Requests are latched in IDLE, issued for one cycle, then completed after MEM_LAT cycles.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned MEM_LAT = MEM_LAT_DEFAULT
) (
    input  logic                clk,
    input  logic                rst,

    input  logic                cpu_req,
    input  logic                cpu_we,
    input  logic [REGWIDTH-1:0] cpu_addr,
    input  logic [REGWIDTH-1:0] cpu_wdata,
    output logic [REGWIDTH-1:0] cpu_rdata,
    output logic                cpu_done,
    output logic                cpu_stall,

    input  logic                ld_req,
    input  logic                ld_we,
    input  logic [REGWIDTH-1:0] ld_addr,
    input  logic [REGWIDTH-1:0] ld_wdata,
    output logic [REGWIDTH-1:0] ld_rdata,
    output logic                ld_done,

    output logic                mem_en,
    output logic                mem_we,
    output logic [REGWIDTH-1:0] mem_addr,
    output logic [REGWIDTH-1:0] mem_wdata,
    input  logic [REGWIDTH-1:0] mem_rdata,

    output logic                busy
);

    state_e              r_state;
    logic [CNT_W-1:0]    r_cnt;
    owner_e              r_rr;
    txn_t                r_txn;
    logic                r_mem_en;
    logic                r_mem_we;
    logic [REGWIDTH-1:0] r_cpu_rdata;
    logic [REGWIDTH-1:0] r_ld_rdata;

    owner_e              w_winner;
    txn_t                w_req_txn;
    logic                w_last;

    always_comb begin
        w_winner        = pick_winner(cpu_req, ld_req, r_rr);
        w_req_txn       = '0;
        w_req_txn.owner = w_winner;
        if (w_winner == OWN_LD) begin
            w_req_txn.we    = ld_we;
            w_req_txn.addr  = ld_addr;
            w_req_txn.wdata = ld_wdata;
        end else begin
            w_req_txn.we    = cpu_we;
            w_req_txn.addr  = cpu_addr;
            w_req_txn.wdata = cpu_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_rr        <= OWN_LD;
            r_txn       <= '0;
            r_mem_en    <= 1'b0;
            r_mem_we    <= 1'b0;
            r_cpu_rdata <= '0;
            r_ld_rdata  <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_mem_en <= 1'b0;
                    r_mem_we <= 1'b0;
                    if (cpu_req || ld_req) begin
                        r_txn    <= w_req_txn;
                        r_rr     <= w_winner;
                        r_mem_en <= 1'b1;
                        r_mem_we <= w_req_txn.we;
                        r_state  <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    r_mem_en <= 1'b0;
                    r_mem_we <= 1'b0;
                    r_cnt    <= CNT_W'(MEM_LAT);
                    r_state  <= ST_WAIT;
                end
                ST_WAIT: begin
                    r_cnt <= r_cnt - CNT_W'(1);
                    // Final wait cycle: memory data is valid now, capture into the owner only.
                    if (w_last) begin
                        r_state <= ST_IDLE;
                        if (!r_txn.we) begin
                            if (r_txn.owner == OWN_LD) begin
                                r_ld_rdata <= mem_rdata;
                            end else begin
                                r_cpu_rdata <= mem_rdata;
                            end
                        end
                    end
                end
                default: begin
                    r_state  <= ST_IDLE;
                    r_mem_en <= 1'b0;
                    r_mem_we <= 1'b0;
                end
            endcase
        end
    end

    assign w_last    = (r_state == ST_WAIT) && (r_cnt == CNT_W'(1));

    assign cpu_done  = w_last && (r_txn.owner == OWN_CPU);
    assign ld_done   = w_last && (r_txn.owner == OWN_LD);
    assign cpu_stall = cpu_req && !cpu_done;
    assign cpu_rdata = r_cpu_rdata;
    assign ld_rdata  = r_ld_rdata;

    assign mem_en    = r_mem_en;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_txn.addr;
    assign mem_wdata = r_txn.wdata;
    assign busy      = (r_state != ST_IDLE);

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter MEM_LAT, default 1: cycles from mem_en to valid mem_rdata; legal range 1..15.
REQ-002 Data and address widths SHALL be `REGWIDTH (32) from variables.vh.
REQ-003 clk  in  1  single clock; all state changes on posedge clk.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 cpu_req  in  1  CPU data-port request; held until cpu_done.
REQ-006 cpu_we  in  1  1 = write, 0 = read.
REQ-007 cpu_addr  in  32  byte address.
REQ-008 cpu_wdata  in  32  write data.
REQ-009 cpu_rdata  out  32  registered read data.
REQ-010 cpu_done  out  1  one-cycle completion pulse.
REQ-011 cpu_stall  out  1  freeze PC/pipeline; equals cpu_req & ~cpu_done.
REQ-012 ld_req, ld_we, ld_addr, ld_wdata, ld_rdata, ld_done  same widths/meanings as cpu_*, for loader/debug port.
REQ-013 mem_en  out  1; mem_we  out  1; mem_addr  out  32; mem_wdata  out  32  single-port data memory controls.
REQ-014 mem_rdata  in  32  memory read data, valid MEM_LAT cycles after mem_en.
REQ-015 busy  out  1  high whenever state is not IDLE.

Function
REQ-016 FSM states IDLE, ISSUE, WAIT; encoding is implementation choice.
REQ-017 Requests SHALL be sampled only in IDLE; in IDLE with any req high, latch owner, we, addr, wdata and go to ISSUE next cycle.
REQ-018 Arbitration: single requester wins; both requesting -> port not granted last (round-robin bit rr); rr updates to winner on grant.
REQ-019 ISSUE: exactly one cycle, mem_en=1, mem_we=latched we, mem_addr/mem_wdata=latched values; load counter with MEM_LAT; go to WAIT.
REQ-020 WAIT: decrement counter each cycle; in the cycle counter==1, assert owner's done, and on read register mem_rdata into owner's rdata; next state IDLE.
REQ-021 Latency: req seen in IDLE at cycle N -> ISSUE at N+1 -> done at N+1+MEM_LAT; same for reads and writes.
REQ-022 mem_en, mem_we SHALL be 0 outside ISSUE; mem_addr/mem_wdata hold latched values (no glitching to requester inputs).
REQ-023 Non-owner done SHALL stay 0; non-owner rdata SHALL hold its previous value; write completions SHALL not change rdata.
REQ-024 A req still high in the IDLE cycle after done is a new transaction (back-to-back allowed; arbitration reapplies).
REQ-025 Requester input changes outside IDLE SHALL have no effect on the current transaction.
REQ-026 No request in IDLE -> remain IDLE, all strobes 0.

Reset
REQ-027 rst SHALL, at the next clk edge, force IDLE, counter=0, rr=1 (CPU wins first tie), cpu_rdata=ld_rdata=0, all latched fields 0.
REQ-028 During reset and the first post-reset cycle: mem_en=0, done=0, busy=0; cpu_stall follows cpu_req.
REQ-029 Reset mid-transaction SHALL abort it with no done pulse; requester re-requests.

Structure
REQ-030 State encoding and MEM_LAT default belong in variables.vh beside `REGWIDTH.
REQ-031 Single module; no sub-modules required (round-robin is one flop).

Verification
REQ-032 MEM_LAT=1, CPU read addr 0x10, memory returns 0xDEADBEEF -> mem_en at N+1, cpu_done at N+2, cpu_rdata=0xDEADBEEF, cpu_stall high N..N+1 only.
REQ-033 Both ports request after reset (CPU write 0x4<-0x11, loader read 0x8) -> CPU served first, loader issues at cycle after CPU done, ld_done 3 cycles later.
REQ-034 Both hold req continuously for 4 transactions -> grants alternate CPU, LD, CPU, LD; no done overlap.
REQ-035 MEM_LAT=3, loader write 0x20<-0xA5A5A5A5 -> ld_done exactly 4 cycles after request cycle, mem_en one cycle, ld_rdata unchanged.
REQ-036 rst asserted in WAIT of CPU read -> no cpu_done, mem_en 0, busy 0 next cycle; repeated read completes normally.
REQ-037 cpu_addr changed 0x10->0x50 during WAIT -> mem_addr remains 0x10 throughout transaction.
